// File: rtl/soma_multi_pkg.sv
// Shared definitions for the soma_multi add/multiply unit.
package soma_multi_pkg;

   // Operand and result width of the arithmetic unit.
   localparam int WIDTH = 16;

   // Function select encodings for the sel input.
   localparam logic SEL_SOMA  = 1'b0;
   localparam logic SEL_MULTI = 1'b1;

   // One row of the shift-and-add multiplier: A shifted to the weight of
   // multiplier bit 'shift', or zero when that multiplier bit is clear.
   // Bits shifted past the top are dropped, which gives the mod 2^WIDTH truncation.
   function automatic logic [WIDTH-1:0] partial_product(
      input logic [WIDTH-1:0] a,
      input logic             b_bit,
      input int               shift
   );
      logic [WIDTH-1:0] row;
      row = '0;
      if (b_bit) begin
         row = a << shift;
      end
      return row;
   endfunction

endpackage

// File: rtl/soma_multi_adder.sv
// Ripple-carry adder built from bit-level full adders; used both for the
// plain sum and as the accumulate stage of the multiplier array.
module soma_multi_adder
   import soma_multi_pkg::*;
#(
   parameter int W = WIDTH
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   // carry[i] is the carry into bit i; carry[W] leaves the top bit.
   logic [W:0] carry;

   assign carry[0] = cin;

   genvar gi;
   generate
      for (gi = 0; gi < W; gi++) begin : g_fa
         logic half;
         // Full adder for bit gi: propagate term reused for sum and carry.
         assign half          = a[gi] ^ b[gi];
         assign sum[gi]       = half ^ carry[gi];
         assign carry[gi + 1] = (a[gi] & b[gi]) | (half & carry[gi]);
      end
   endgenerate

   assign cout = carry[W];

endmodule

// File: rtl/soma_multi.sv
// 16-bit add / multiply unit for the datapath ALU. sel chooses A+B or A*B,
// both unsigned and truncated to WIDTH bits; the result is registered and
// appears on saida one clock later. All arithmetic is structural.
module soma_multi
   import soma_multi_pkg::*;
(
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             sel,
   output logic [WIDTH-1:0] saida,
   input  logic             clk,
   input  logic             rst_n
);

   // ---------------------------------------------------------------
   // Adder path: carry-out is discarded (wrap-around addition).
   // ---------------------------------------------------------------
   logic [WIDTH-1:0] soma_value;
   logic             unused_soma_cout;

   soma_multi_adder #(.W(WIDTH)) u_soma (
      .a    (A),
      .b    (B),
      .cin  (1'b0),
      .sum  (soma_value),
      .cout (unused_soma_cout)
   );

   // ---------------------------------------------------------------
   // Multiplier path: shift-and-add array. Row i holds A<<i when B[i]
   // is set; rows are summed by a chain of WIDTH-1 adders. Everything
   // above bit WIDTH-1 is dropped, so the chain yields A*B mod 2^WIDTH.
   // ---------------------------------------------------------------
   logic [WIDTH-1:0] pp  [WIDTH];
   logic [WIDTH-1:0] acc [WIDTH];
   logic [WIDTH-1:1] unused_multi_cout;
   logic [WIDTH-1:0] multi_value;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_pp
         assign pp[gi] = partial_product(A, B[gi], gi);
      end
   endgenerate

   // The first row seeds the accumulation; no adder needed for it.
   assign acc[0] = pp[0];

   generate
      for (gi = 1; gi < WIDTH; gi++) begin : g_acc
         soma_multi_adder #(.W(WIDTH)) u_acc (
            .a    (acc[gi - 1]),
            .b    (pp[gi]),
            .cin  (1'b0),
            .sum  (acc[gi]),
            .cout (unused_multi_cout[gi])
         );
      end
   endgenerate

   assign multi_value = acc[WIDTH - 1];

   // ---------------------------------------------------------------
   // Result select and output register.
   // ---------------------------------------------------------------
   logic [WIDTH-1:0] saida_next;
   logic [WIDTH-1:0] saida_reg;

   // Pick the function requested for this cycle ahead of the register.
   always_comb begin
      saida_next = soma_value;
      if (sel == SEL_MULTI) begin
         saida_next = multi_value;
      end
   end

   // Output register: cleared immediately by reset, otherwise loads every edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         saida_reg <= '0;
      end else begin
         saida_reg <= saida_next;
      end
   end

   assign saida = saida_reg;

endmodule

// File: tb/tb_soma_multi.sv
// Directed and random checks for soma_multi: reset behaviour, add/multiply
// results, wrap-around, mid-cycle input changes and async reset mid-stream.
module tb_soma_multi;

   logic [15:0] a;
   logic [15:0] b;
   logic        s;
   logic [15:0] saida;
   logic        clk;
   logic        rst_n;

   int errors = 0;
   int checks = 0;

   soma_multi dut (
      .A     (a),
      .B     (b),
      .sel   (s),
      .saida (saida),
      .clk   (clk),
      .rst_n (rst_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        sel;
      logic [15:0] expected;
      string       name;
   } vec_t;

   vec_t vecs [13];

   task automatic check(input logic [15:0] actual, input logic [15:0] expected,
                        input string name);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: saida=%h expected=%h", name, actual, expected);
      end else begin
         $display("ok   %s: saida=%h", name, actual);
      end
   endtask

   // Drive operands away from the edge, then check one cycle later.
   task automatic apply(input logic [15:0] va, input logic [15:0] vb,
                        input logic vs, input logic [15:0] expected,
                        input string name);
      @(negedge clk);
      a = va;
      b = vb;
      s = vs;
      @(posedge clk);
      #1;
      check(saida, expected, name);
   endtask

   initial begin
      logic [15:0] ra;
      logic [15:0] rb;
      logic        rs;
      logic [31:0] prod;
      logic [16:0] sum;

      vecs[0]  = '{16'h0002, 16'h0003, 1'b0, 16'h0005, "add_2_3"};
      vecs[1]  = '{16'h0002, 16'h0003, 1'b1, 16'h0006, "mul_2_3"};
      vecs[2]  = '{16'h0004, 16'h0002, 1'b0, 16'h0006, "add_4_2"};
      vecs[3]  = '{16'h0004, 16'h0002, 1'b1, 16'h0008, "mul_4_2"};
      vecs[4]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, "add_wrap"};
      vecs[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'h0001, "mul_ffff_ffff"};
      vecs[6]  = '{16'h0100, 16'h0100, 1'b1, 16'h0000, "mul_0100_0100"};
      vecs[7]  = '{16'h8000, 16'h0002, 1'b1, 16'h0000, "mul_8000_2"};
      vecs[8]  = '{16'h1234, 16'h0000, 1'b0, 16'h1234, "add_zero"};
      vecs[9]  = '{16'h1234, 16'h0000, 1'b1, 16'h0000, "mul_zero"};
      vecs[10] = '{16'h1234, 16'h0001, 1'b1, 16'h1234, "mul_one"};
      vecs[11] = '{16'h00FF, 16'h00FF, 1'b1, 16'hFE01, "mul_ff_ff"};
      vecs[12] = '{16'h7FFF, 16'h7FFF, 1'b0, 16'hFFFE, "add_7fff"};

      // Reset asserted from time 0, no clock edge yet.
      rst_n = 1'b0;
      a = 16'h0002;
      b = 16'h0003;
      s = 1'b0;
      #1;
      check(saida, 16'h0000, "reset_no_edge");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check(saida, 16'h0000, $sformatf("reset_hold_%0d", i));
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table.
      for (int i = 0; i < 13; i++) begin
         apply(vecs[i].a, vecs[i].b, vecs[i].sel, vecs[i].expected, vecs[i].name);
      end

      // Mid-cycle input change must not reach saida before the next edge.
      apply(16'h0004, 16'h0002, 1'b1, 16'h0008, "pre_mid_change");
      #2;
      a = 16'h0005;
      s = 1'b0;
      #1;
      check(saida, 16'h0008, "mid_change_no_edge");
      @(posedge clk);
      #1;
      check(saida, 16'h0007, "mid_change_next_edge");

      // Async reset between edges clears saida immediately and holds.
      apply(16'h0004, 16'h0002, 1'b1, 16'h0008, "pre_async_rst");
      #2;
      rst_n = 1'b0;
      #1;
      check(saida, 16'h0000, "async_rst_immediate");
      @(posedge clk);
      #1;
      check(saida, 16'h0000, "async_rst_held_edge");
      @(negedge clk);
      rst_n = 1'b1;

      // Random vectors against a behavioural model, one cycle latency.
      for (int i = 0; i < 1000; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         rs = 1'($urandom_range(0, 1));
         prod = {16'h0000, ra} * {16'h0000, rb};
         sum  = {1'b0, ra} + {1'b0, rb};
         apply(ra, rb, rs, rs ? prod[15:0] : sum[15:0],
               $sformatf("rand_%0d_%h_%s_%h", i, ra, rs ? "mul" : "add", rb));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
